// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared TCAM sizing and match-reader state type
package tcam_pkg;

  localparam int TCAM_ENTRIES = 16;
  localparam int TCAM_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } tcam_rd_state_t;

endpackage

// File: rtl/tcam_match_reader_if.sv
// rtl/tcam_match_reader_if.sv - search-capture and index-stream bundle; hit_count only with TCAM_MATCH_COUNT_EN
interface tcam_match_reader_if #(
  parameter int ENTRIES = tcam_pkg::TCAM_ENTRIES,
  parameter int IDX_W   = tcam_pkg::TCAM_IDX_W
);

  logic               start;
  logic [ENTRIES-1:0] hits;
  logic               busy;
  logic               index_valid;
  logic [IDX_W-1:0]   index;
  logic               index_ready;
  logic               done;
  logic               no_match;
`ifdef TCAM_MATCH_COUNT_EN
  logic [IDX_W:0]     hit_count;
`endif

  modport master (
    input  start, hits, index_ready,
`ifdef TCAM_MATCH_COUNT_EN
    output hit_count,
`endif
    output busy, index_valid, index, done, no_match
  );

  modport slave (
    output start, hits, index_ready,
`ifdef TCAM_MATCH_COUNT_EN
    input  hit_count,
`endif
    input  busy, index_valid, index, done, no_match
  );

endinterface

// File: rtl/tcam_lsb_encoder.sv
// rtl/tcam_lsb_encoder.sv - combinational lowest-set-bit finder, shared with the CAM single-hit priority path
module tcam_lsb_encoder #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Scanning downward lets the lowest set bit be the last assignment to win.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcam_match_reader.sv
// rtl/tcam_match_reader.sv - captures one CAM hits vector and streams matched indices lowest first
// Optional hit_count popcount output is enabled by defining TCAM_MATCH_COUNT_EN.
module tcam_match_reader
  import tcam_pkg::*;
#(
  parameter int ENTRIES = TCAM_ENTRIES,
  parameter int IDX_W   = TCAM_IDX_W
) (
  input  logic                clk,
  input  logic                reset,
  tcam_match_reader_if.master bus
);

  tcam_rd_state_t     state;
  tcam_rd_state_t     state_next;
  logic [ENTRIES-1:0] pending;
  logic [ENTRIES-1:0] pending_cleared;
  logic [IDX_W-1:0]   lsb_index;
  logic               lsb_any;
  logic               no_match_q;
  logic               accept;
  logic               handshake;

  tcam_lsb_encoder #(
    .WIDTH (ENTRIES),
    .IDX_W (IDX_W)
  ) u_lsb_encoder (
    .vec   (pending),
    .index (lsb_index),
    .any   (lsb_any)
  );

  assign accept          = (state == IDLE) && bus.start;
  assign handshake       = (state == SCAN) && lsb_any && bus.index_ready;
  assign pending_cleared = pending & ~(ENTRIES'(1) << lsb_index);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (|bus.hits) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (handshake && (pending_cleared == '0)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the captured copy drives the stream; hits is ignored until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      no_match_q <= 1'b0;
    end else if (accept) begin
      pending    <= bus.hits;
      no_match_q <= ~(|bus.hits);
    end else if (handshake) begin
      pending    <= pending_cleared;
    end
  end

`ifdef TCAM_MATCH_COUNT_EN
  logic [IDX_W:0] hit_count_q;
  logic [IDX_W:0] hits_popcount;

  always_comb begin
    hits_popcount = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hits_popcount = hits_popcount + {{IDX_W{1'b0}}, bus.hits[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q <= '0;
    end else if (accept) begin
      hit_count_q <= hits_popcount;
    end
  end

  assign bus.hit_count = hit_count_q;
`endif

  always_comb begin
    bus.busy        = (state != IDLE);
    bus.index_valid = (state == SCAN) && lsb_any;
    bus.index       = lsb_index;
    bus.done        = (state == DONE);
    bus.no_match    = (state == DONE) && no_match_q;
  end

endmodule

// File: tb/tb_tcam_match_reader.sv
// tb/tb_tcam_match_reader.sv - scoreboard bench for tcam_match_reader
module tb_tcam_match_reader;
  import tcam_pkg::*;

  localparam int DONE_HIT  = 100;
  localparam int DONE_NONE = 101;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  tcam_match_reader_if bus ();

  tcam_match_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [15:0] h);
    for (int i = 0; i < 16; i++) begin
      if (h[i]) exp_q.push_back(i);
    end
    exp_q.push_back((h == 16'h0) ? DONE_NONE : DONE_HIT);
  endtask

  // Called at #1 after a rising edge while idle; returns #1 after the capture edge.
  task automatic do_start(input logic [15:0] h);
    push_expected(h);
    bus.hits  = h;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    check_eq("idle_timeout", bus.busy, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.index_valid && bus.index_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_index", bus.index, 999);
        else check_eq("stream_index", bus.index, exp_q.pop_front());
      end
      if (bus.done) begin
        if (exp_q.size() == 0) check_eq("unexpected_done", bus.no_match, 999);
        else check_eq("done_kind", bus.no_match ? DONE_NONE : DONE_HIT, exp_q.pop_front());
      end
      check_eq("no_match_outside_done", bus.no_match & ~bus.done, 0);
      check_eq("busy_decode", bus.busy, bus.index_valid | bus.done);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.hits        = '0;
    bus.index_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_valid", bus.index_valid, 0);
    check_eq("rst_index", bus.index, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_no_match", bus.no_match, 0);
`ifdef TCAM_MATCH_COUNT_EN
    check_eq("rst_hit_count", bus.hit_count, 0);
`endif
    reset = 1'b0;
    step();

    // Empty vector: done plus no_match straight away, never a valid index.
    do_start(16'h0000);
    check_eq("zero_done", bus.done, 1);
    check_eq("zero_no_match", bus.no_match, 1);
    check_eq("zero_valid", bus.index_valid, 0);
`ifdef TCAM_MATCH_COUNT_EN
    check_eq("zero_hit_count", bus.hit_count, 0);
`endif
    step();
    check_eq("zero_done_pulse", bus.done, 0);
    check_eq("zero_no_match_clr", bus.no_match, 0);
    wait_idle();

    // Full-rate drain of 0,5,10,15, then a start during done that must be ignored.
    bus.index_ready = 1'b1;
    do_start(16'h8421);
`ifdef TCAM_MATCH_COUNT_EN
    check_eq("h8421_hit_count", bus.hit_count, 4);
`endif
    for (int k = 0; k < 4; k++) begin
      check_eq("h8421_valid", bus.index_valid, 1);
      check_eq("h8421_index", bus.index, 5 * k);
      step();
    end
    check_eq("h8421_done", bus.done, 1);
    check_eq("h8421_no_match", bus.no_match, 0);
    bus.hits  = 16'h0001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_eq("start_in_done_ignored", bus.busy, 0);

    // Stall with ready low: index 1 must hold for three cycles.
    bus.index_ready = 1'b0;
    do_start(16'h0006);
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_valid", bus.index_valid, 1);
      check_eq("stall_index", bus.index, 1);
      if (k < 2) step();
    end
    bus.index_ready = 1'b1;
    step();
    check_eq("stall_next_index", bus.index, 2);
    wait_idle();

    // Restart and a hits change mid-scan must not disturb the captured vector.
    do_start(16'h8421);
    bus.hits  = 16'hFFFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_idle();

    // Reset in the second scan cycle drops the in-flight index.
    do_start(16'h00F0);
    check_eq("rst_scan_first", bus.index, 4);
    step();
    check_eq("rst_scan_second", bus.index, 5);
    reset = 1'b1;
    exp_q.delete();
    step();
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_valid", bus.index_valid, 0);
    check_eq("midrst_index", bus.index, 0);
    check_eq("midrst_done", bus.done, 0);
    check_eq("midrst_no_match", bus.no_match, 0);
`ifdef TCAM_MATCH_COUNT_EN
    check_eq("midrst_hit_count", bus.hit_count, 0);
`endif
    reset = 1'b0;
    step();
    do_start(16'h0001);
    check_eq("post_rst_index", bus.index, 0);
    check_eq("post_rst_valid", bus.index_valid, 1);
    wait_idle();

    // All sixteen entries matched.
    do_start(16'hFFFF);
`ifdef TCAM_MATCH_COUNT_EN
    check_eq("full_hit_count", bus.hit_count, 16);
`endif
    for (int k = 0; k < 16; k++) begin
      check_eq("full_index", bus.index, k);
      step();
    end
    check_eq("full_done", bus.done, 1);
    wait_idle();
`ifdef TCAM_MATCH_COUNT_EN
    check_eq("full_hit_count_hold", bus.hit_count, 16);
`endif

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
